// File: rtl/clk_domain_sequencer_pkg.sv
// Shared types and helpers for the post-PLL clock-domain sequencer.
package clk_seq_pkg;

   // Sequencer states, kept as plain 2-bit constants for legacy compatibility.
   typedef logic [1:0] state_t;
   localparam state_t WAIT_LOCK = 2'd0;
   localparam state_t STABLE    = 2'd1;
   localparam state_t RELEASE   = 2'd2;
   localparam state_t RUN       = 2'd3;

   localparam int LOL_W = 8;

   // Width needed to index/count n values, never narrower than one bit.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_domain_sequencer_if.sv
// Ratio-configuration bus: one-cycle write strobe with channel select and INC/MOD values.
interface clk_domain_sequencer_if #(
   parameter int CH_W  = 2,
   parameter int ACC_W = 16
) ();
   logic             cfg_we_i;
   logic [CH_W-1:0]  cfg_ch_i;
   logic [ACC_W-1:0] cfg_inc_i;
   logic [ACC_W-1:0] cfg_mod_i;

   modport master (output cfg_we_i, cfg_ch_i, cfg_inc_i, cfg_mod_i);
   modport slave  (input  cfg_we_i, cfg_ch_i, cfg_inc_i, cfg_mod_i);
endinterface

// File: rtl/clk_domain_sequencer_frac_ce.sv
// One fractional clock-enable channel: ce rate = clk * INC/MOD, ratio updated only at pulses.
module clk_frac_ce #(
   parameter int ACC_W   = 16,
   parameter int DEF_INC = 1,
   parameter int DEF_MOD = 10
) (
   input  logic             clk_i,
   input  logic             reset,
   input  logic             run,
   input  logic             we,
   input  logic [ACC_W-1:0] inc_wr,
   input  logic [ACC_W-1:0] mod_wr,
   output logic             ce
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc_sh, mod_sh, inc_act, mod_act;
   logic [ACC_W-1:0] inc_nxt, mod_nxt;
   logic [ACC_W:0]   sum;
   logic             degen, hit;

   // A write in the same cycle as a pulse is the newest ratio, so it is the one promoted.
   always_comb begin
      inc_nxt = we ? inc_wr : inc_sh;
      mod_nxt = we ? mod_wr : mod_sh;
      sum     = {1'b0, acc} + {1'b0, inc_act};
      degen   = (mod_act == '0) || (inc_act >= mod_act);
      hit     = degen || (sum >= {1'b0, mod_act});
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         acc     <= '0;
         ce      <= 1'b0;
         inc_sh  <= ACC_W'(DEF_INC);
         mod_sh  <= ACC_W'(DEF_MOD);
         inc_act <= ACC_W'(DEF_INC);
         mod_act <= ACC_W'(DEF_MOD);
      end else begin
         inc_sh <= inc_nxt;
         mod_sh <= mod_nxt;
         if (!run) begin
            acc     <= '0;
            ce      <= 1'b0;
            inc_act <= inc_nxt;
            mod_act <= mod_nxt;
         end else begin
            ce <= hit;
            if (degen)
               acc <= '0;
            else if (hit)
               acc <= ACC_W'(sum - {1'b0, mod_act});
            else
               acc <= sum[ACC_W-1:0];
            if (hit) begin
               inc_act <= inc_nxt;
               mod_act <= mod_nxt;
            end
         end
      end
   end

endmodule

// File: rtl/clk_domain_sequencer.sv
// Post-PLL clock manager: lock supervision, staggered domain-reset release, per-channel fractional enables.
// Optional macro CLKSEQ_LOCK_SYNC_EN adds a 2-flop synchronizer on locked_i.
module clk_domain_sequencer
   import clk_seq_pkg::*;
#(
   parameter int N_CH            = 3,
   parameter int ACC_W           = 16,
   parameter int LOCK_STABLE_CYC = 1024,
   parameter int RST_STAGGER     = 16,
   parameter int DEF_INC         = 1,
   parameter int DEF_MOD         = 10
) (
   input  logic                   clk_i,
   input  logic                   reset,
   input  logic                   locked_i,
   clk_domain_sequencer_if.slave  cfg,
   output logic [N_CH-1:0]        ce_o,
   output logic [N_CH-1:0]        rst_o,
   output logic                   ready_o,
   output logic [LOL_W-1:0]       lol_cnt_o
);

   localparam int CH_W   = ch_w(N_CH);
   localparam int STAB_W = ch_w(LOCK_STABLE_CYC);
   localparam int STAG_W = ch_w(RST_STAGGER);

   logic lock;

`ifdef CLKSEQ_LOCK_SYNC_EN
   logic [1:0] lock_sync;

   always_ff @(posedge clk_i) begin
      if (reset)
         lock_sync <= '0;
      else
         lock_sync <= {lock_sync[0], locked_i};
   end

   assign lock = lock_sync[1];
`else
   assign lock = locked_i;
`endif

   state_t             state;
   logic [STAB_W-1:0]  stab_cnt;
   logic [STAG_W-1:0]  stag_cnt;
   logic               lol_evt;

   assign lol_evt = !lock && ((state == RELEASE) || (state == RUN));

   // rst_o releases from bit 0 upward, so each release step is a left shift that pulls in a 0.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state     <= WAIT_LOCK;
         stab_cnt  <= '0;
         stag_cnt  <= '0;
         rst_o     <= '1;
         ready_o   <= 1'b0;
         lol_cnt_o <= '0;
      end else if (!lock) begin
         state    <= WAIT_LOCK;
         stab_cnt <= '0;
         rst_o    <= '1;
         ready_o  <= 1'b0;
         if (lol_evt && (lol_cnt_o != '1))
            lol_cnt_o <= lol_cnt_o + LOL_W'(1);
      end else begin
         case (state)
            WAIT_LOCK: begin
               state    <= STABLE;
               stab_cnt <= '0;
            end
            STABLE: begin
               if (stab_cnt == STAB_W'(LOCK_STABLE_CYC - 1)) begin
                  state    <= RELEASE;
                  rst_o    <= rst_o << 1;
                  stag_cnt <= '0;
               end else begin
                  stab_cnt <= stab_cnt + STAB_W'(1);
               end
            end
            RELEASE: begin
               if (!rst_o[N_CH-1]) begin
                  state   <= RUN;
                  ready_o <= 1'b1;
               end else if (stag_cnt == STAG_W'(RST_STAGGER - 1)) begin
                  rst_o    <= rst_o << 1;
                  stag_cnt <= '0;
               end else begin
                  stag_cnt <= stag_cnt + STAG_W'(1);
               end
            end
            RUN: ready_o <= 1'b1;
            default: state <= WAIT_LOCK;
         endcase
      end
   end

   // A channel runs only once its reset is released and lock is still present this cycle.
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      clk_frac_ce #(
         .ACC_W   (ACC_W),
         .DEF_INC (DEF_INC),
         .DEF_MOD (DEF_MOD)
      ) u_ce (
         .clk_i  (clk_i),
         .reset  (reset),
         .run    (!rst_o[k] && lock),
         .we     (cfg.cfg_we_i && (cfg.cfg_ch_i == CH_W'(k))),
         .inc_wr (cfg.cfg_inc_i),
         .mod_wr (cfg.cfg_mod_i),
         .ce     (ce_o[k])
      );
   end

endmodule
